alu_regfile_unit: RTL and testbench

Parametrised successor to the board-level ALU test harness. It pairs the Hack-style six-control-bit ALU with a two-read-port operand register file and a hardware init sequencer. Operation requests use a valid/ready handshake through a two-stage pipeline. Optionally the result is written back into the register file. It sits between the board I/O (switches, seven-segment flag display) and the future CPU datapath, and is the operand/execute core the CPU will reuse.

---
 rtl/alu_regfile_unit.sv | 194 +++++++++++++++++++
 tb/tb_alu_regfile_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_regfile_unit
//  Purpose  : Hack-style six-control-bit ALU fed by a two-read-port operand
//             register file. A hardware sequencer loads the file at start-up.
//             Requests use a valid/ready handshake. The pipeline is an accept
//             register, a synchronous operand read and a registered ALU result.
//  Options  : ALU_WRITEBACK_EN - adds the wb_en/wb_addr ports, the result
//             writeback path and the two-cycle writeback stall.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_regfile_unit #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_start,
   output logic             busy,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   input  logic [5:0]       ctrl,
`ifdef ALU_WRITEBACK_EN
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
`endif
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             res_valid,
   output logic [WIDTH-1:0] result,
   output logic             zr,
   output logic             ng
);

   localparam int      HALF = DEPTH / 2;
   localparam [AW-1:0] LAST = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [AW-1:0]    init_cnt;
   logic [WIDTH-1:0] init_val;
   logic [WIDTH-1:0] rf [DEPTH];

   logic             accept;
   logic             flush;
   logic             wb_stall;

   // Stage 1: captured request
   logic             s1_valid;
   logic [AW-1:0]    s1_addr_a;
   logic [AW-1:0]    s1_addr_b;
   logic [5:0]       s1_ctrl;

   // Stage 2: operands read from the register file
   logic             s2_valid;
   logic [WIDTH-1:0] s2_x;
   logic [WIDTH-1:0] s2_y;
   logic [5:0]       s2_ctrl;

`ifdef ALU_WRITEBACK_EN
   logic             s1_wb_en;
   logic [AW-1:0]    s1_wb_addr;
   logic             s2_wb_en;
   logic [AW-1:0]    s2_wb_addr;
   logic             wb_fire;
`endif

   logic [WIDTH-1:0] alu_o;

   // An init_start aborts everything in flight, so it flushes like rst
   assign flush  = rst || init_start;
   assign busy   = (state == INIT);

`ifdef ALU_WRITEBACK_EN
   // Hold off new requests until the writeback lands, since there is no forwarding
   assign wb_stall = (s1_valid && s1_wb_en) || (s2_valid && s2_wb_en);
   assign wb_fire  = s2_valid && s2_wb_en && !init_start;
`else
   assign wb_stall = 1'b0;
`endif

   assign op_ready = (state == RUN) && !init_start && !wb_stall;
   assign accept   = op_valid && op_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= INIT;
      else     state <= state_next;
   end

   // Next state: leave INIT after the last entry, re-enter on init_start
   always_comb begin
      state_next = state;
      case (state)
         INIT: if (!init_start && init_cnt == LAST) state_next = RUN;
         RUN:  if (init_start) state_next = INIT;
         default: state_next = INIT;
      endcase
   end

   // Init counter: walks the entries in INIT and sits at zero otherwise
   always_ff @(posedge clk) begin
      if (rst || init_start || state == RUN) init_cnt <= '0;
      else                                   init_cnt <= init_cnt + AW'(1);
   end

   // Init pattern: lower half gets its index, upper half gets -1, -2, ...
   always_comb begin
      init_val = WIDTH'(init_cnt);
      if (init_cnt >= AW'(HALF)) init_val = ~WIDTH'(init_cnt - AW'(HALF));
   end

   // Register file writes; writeback is assigned last so it wins a collision
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            if (!init_start) rf[init_cnt] <= init_val;
         end else begin
            if (wr_en) rf[wr_addr] <= wr_data;
`ifdef ALU_WRITEBACK_EN
            if (wb_fire) rf[s2_wb_addr] <= alu_o;
`endif
         end
      end
   end

   // Stage 1: capture the request fields at acceptance
   always_ff @(posedge clk) begin
      if (flush) s1_valid <= 1'b0;
      else       s1_valid <= accept;
      if (accept) begin
         s1_addr_a <= addr_a;
         s1_addr_b <= addr_b;
         s1_ctrl   <= ctrl;
`ifdef ALU_WRITEBACK_EN
         s1_wb_en   <= wb_en;
         s1_wb_addr <= wb_addr;
`endif
      end
   end

   // Stage 2: synchronous operand read; a same-edge write is not yet visible
   always_ff @(posedge clk) begin
      if (flush) s2_valid <= 1'b0;
      else       s2_valid <= s1_valid;
      if (s1_valid) begin
         s2_x    <= rf[s1_addr_a];
         s2_y    <= rf[s1_addr_b];
         s2_ctrl <= s1_ctrl;
`ifdef ALU_WRITEBACK_EN
         s2_wb_en   <= s1_wb_en;
         s2_wb_addr <= s1_wb_addr;
`endif
      end
   end

   // ALU: ctrl = {zx, nx, zy, ny, f, no}
   always_comb begin
      logic [WIDTH-1:0] x1, x2, y1, y2, o;
      x1    = s2_ctrl[5] ? '0 : s2_x;
      x2    = s2_ctrl[4] ? ~x1 : x1;
      y1    = s2_ctrl[3] ? '0 : s2_y;
      y2    = s2_ctrl[2] ? ~y1 : y1;
      o     = s2_ctrl[1] ? (x2 + y2) : (x2 & y2);
      alu_o = s2_ctrl[0] ? ~o : o;
   end

   // Output register: result and flags hold between strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         result    <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
      end else begin
         res_valid <= s2_valid && !init_start;
         if (s2_valid && !init_start) begin
            result <= alu_o;
            zr     <= (alu_o == '0);
            ng     <= alu_o[WIDTH-1];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_regfile_unit
//  Purpose  : Directed self-checking bench for alu_regfile_unit with a
//             scoreboard queue of expected results and a register-file model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_regfile_unit;

   localparam int WIDTH = 16;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             init_start = 1'b0;
   logic             busy;
   logic             op_valid = 1'b0;
   logic             op_ready;
   logic [AW-1:0]    addr_a = '0;
   logic [AW-1:0]    addr_b = '0;
   logic [5:0]       ctrl = '0;
`ifdef ALU_WRITEBACK_EN
   logic             wb_en = 1'b0;
   logic [AW-1:0]    wb_addr = '0;
`endif
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             res_valid;
   logic [WIDTH-1:0] result;
   logic             zr;
   logic             ng;

   typedef struct {
      int               due;
      logic [WIDTH-1:0] r;
      logic             z;
      logic             n;
   } exp_t;

   exp_t             q[$];
   logic [WIDTH-1:0] mdl [DEPTH];
   int               cyc = 0;
   int               n_checks = 0;
   int               n_fail = 0;

   alu_regfile_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .init_start (init_start),
      .busy       (busy),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .ctrl       (ctrl),
`ifdef ALU_WRITEBACK_EN
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
`endif
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .res_valid  (res_valid),
      .result     (result),
      .zr         (zr),
      .ng         (ng)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic [5:0] c);
      logic [WIDTH-1:0] a, b, o;
      a = c[5] ? 16'h0 : x;
      if (c[4]) a = ~a;
      b = c[3] ? 16'h0 : y;
      if (c[2]) b = ~b;
      o = c[1] ? a + b : a & b;
      return c[0] ? ~o : o;
   endfunction

   task automatic model_init();
      for (int i = 0; i < DEPTH; i++)
         mdl[i] = (i < DEPTH/2) ? 16'(i) : 16'(-(i - DEPTH/2 + 1));
   endtask

   // Scoreboard: every strobe must match the oldest expectation, on time
   always @(negedge clk) begin
      if (res_valid === 1'b1) begin
         logic has;
         has = (q.size() > 0);
         check("res_valid_expected", {31'd0, has}, 32'd1);
         if (has) begin
            exp_t e;
            e = q.pop_front();
            check("result", {16'd0, result}, {16'd0, e.r});
            check("zr", {31'd0, zr}, {31'd0, e.z});
            check("ng", {31'd0, ng}, {31'd0, e.n});
            check("latency_cycle", cyc, e.due);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request; waits (bounded) for op_ready and records the expectation
   task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [5:0] c,
                       input bit expect_res);
      int   waited;
      exp_t e;
      waited = 0;
      op_valid = 1'b1;
      addr_a = a;
      addr_b = b;
      ctrl = c;
      @(negedge clk);
      while (op_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("op_ready_for_send", {31'd0, op_ready}, 32'd1);
      if (expect_res) begin
         e.due = cyc + 3;
         e.r   = alu(mdl[a], mdl[b], c);
         e.z   = (e.r == 16'h0);
         e.n   = e.r[WIDTH-1];
         q.push_back(e);
      end
      tick();
      op_valid = 1'b0;
   endtask

   task automatic ext_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      mdl[a] = d;
   endtask

   task automatic count_busy(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      check({tag, "_op_ready_low"}, {31'd0, op_ready}, 32'd0);
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      op_valid = 1'b0;
      wr_en = 1'b0;
      check({tag, "_busy_cycles"}, n, DEPTH);
      check({tag, "_op_ready_after"}, {31'd0, op_ready}, 32'd1);
   endtask

   initial begin
      model_init();
      // Reset state
      tick();
      tick();
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_op_ready", {31'd0, op_ready}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_zr", {31'd0, zr}, 32'd0);
      check("rst_ng", {31'd0, ng}, 32'd0);
      tick();
      rst = 1'b0;
      count_busy("init");
      check("post_init_result", {16'd0, result}, 32'd0);
      tick();

      // Addition, zero flag, subtraction with negative flag
      send(5'd3, 5'd1, 6'b000010, 1'b1);
      send(5'd16, 5'd1, 6'b000010, 1'b1);
      send(5'd2, 5'd3, 6'b010011, 1'b1);
      repeat (4) tick();

      // Four back-to-back operations
      send(5'd5, 5'd6, 6'b000010, 1'b1);
      send(5'd31, 5'd0, 6'b000010, 1'b1);
      send(5'd7, 5'd7, 6'b000000, 1'b1);
      send(5'd10, 5'd4, 6'b000111, 1'b1);
      repeat (4) tick();

      // External write visible on a later read
      ext_write(5'd9, 16'h1234);
      send(5'd9, 5'd0, 6'b001100, 1'b1);
      repeat (4) tick();

      // Write in the same cycle as the operand read returns the old value
      send(5'd8, 5'd0, 6'b001100, 1'b1);
      wr_en = 1'b1;
      wr_addr = 5'd8;
      wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0;
      mdl[8] = 16'hBEEF;
      repeat (3) tick();
      send(5'd8, 5'd0, 6'b001100, 1'b1);
      repeat (4) tick();

`ifdef ALU_WRITEBACK_EN
      // Writeback stalls two cycles, then the new value is readable
      wb_en = 1'b1;
      wb_addr = 5'd5;
      send(5'd3, 5'd3, 6'b000010, 1'b1);
      wb_en = 1'b0;
      mdl[5] = 16'h0006;
      @(negedge clk);
      check("wb_stall_1", {31'd0, op_ready}, 32'd0);
      @(negedge clk);
      check("wb_stall_2", {31'd0, op_ready}, 32'd0);
      @(negedge clk);
      check("wb_stall_end", {31'd0, op_ready}, 32'd1);
      tick();
      send(5'd5, 5'd0, 6'b001100, 1'b1);
      repeat (4) tick();
`endif

      // Init abort with an operation in flight; writes and requests ignored in INIT
      ext_write(5'd5, 16'h0055);
      send(5'd5, 5'd0, 6'b001100, 1'b1);
      repeat (4) tick();
      send(5'd3, 5'd1, 6'b000010, 1'b0);
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      wr_en = 1'b1;
      wr_addr = 5'd2;
      wr_data = 16'hAAAA;
      op_valid = 1'b1;
      addr_a = 5'd1;
      addr_b = 5'd1;
      ctrl = 6'b000010;
      count_busy("abort");
      model_init();
      tick();
      send(5'd5, 5'd0, 6'b001100, 1'b1);
      send(5'd2, 5'd0, 6'b001100, 1'b1);
      send(5'd17, 5'd20, 6'b000010, 1'b1);
      repeat (6) tick();

      check("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
